// File: rtl/ppu_fetch_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_fetch_tracker_pkg
//  Purpose  : Shared mapper definitions for the PPU fetch tracker: access
//             kinds, scanline FSM states, bus layout constants and the
//             read-address classifier.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ppu_fetch_tracker_pkg;

    typedef enum logic [2:0] {
        FK_NT = 3'd0,
        FK_AT = 3'd1,
        FK_PT = 3'd2,
        FK_WR = 3'd3
    } PpuFetchKind;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUP1 = 2'd2,
        ST_DUP2 = 2'd3
    } ScanState;

    // Attribute-table entries live at $23C0-$23FF (and mirrors): A[9:6] all ones.
    localparam logic [3:0] AT_MASK = 4'hF;

    localparam int unsigned PPU_AW = 14;
    // Synchronized bus layout: {addr[13:0], oe_n, we_n}
    localparam int unsigned BUS_W  = PPU_AW + 2;
    localparam logic [BUS_W-1:0] BUS_IDLE = {{PPU_AW{1'b0}}, 2'b11};

    function automatic PpuFetchKind classify_read(input logic [PPU_AW-1:0] addr);
        PpuFetchKind kind;
        if (!addr[13]) begin
            kind = FK_PT;
        end else if (addr[9:6] == AT_MASK) begin
            kind = FK_AT;
        end else begin
            kind = FK_NT;
        end
        return kind;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_edge_sync
//  Purpose  : N-stage synchronizer for a parallel bus plus one extra history
//             flop, so the consumer can compare consecutive synchronized
//             samples (s_prev, s_cur) for edge detection.
//  Ports    : clk, rst_n       - clock, async active-low reset
//             d_i     [WIDTH]  - raw asynchronous bus
//             s_cur_o [WIDTH]  - newest synchronized sample
//             s_prev_o[PREV_W] - previous sample, low PREV_W bits only
//             valid_o          - chain (incl. history flop) refilled since reset
//  Revision : 1.0 - initial release
// ============================================================================
module ppu_edge_sync #(
    parameter int unsigned      WIDTH   = 16,
    parameter int unsigned      STAGES  = 2,
    parameter int unsigned      PREV_W  = WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  d_i,
    output logic [WIDTH-1:0]  s_cur_o,
    output logic [PREV_W-1:0] s_prev_o,
    output logic              valid_o
);

    // After reset the chain holds idle values while the pins may not; the
    // first STAGES+1 clocks shift real pin data in and must not be judged.
    localparam int unsigned FILL   = STAGES + 1;
    localparam int unsigned FILL_W = $clog2(FILL + 1);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(FILL);

    logic [PREV_W-1:0] prev_q;
    logic [FILL_W-1:0] fill_q;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) q <= RST_VAL;
                    else        q <= d_i;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) q <= RST_VAL;
                    else        q <= g_stage[gi-1].q;
                end
            end
        end
    endgenerate

    assign s_cur_o = g_stage[STAGES-1].q;

    // Only the low bits are kept in history; the consumer needs the strobes,
    // not the previous address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RST_VAL[PREV_W-1:0];
            fill_q <= '0;
        end else begin
            prev_q <= s_cur_o[PREV_W-1:0];
            if (fill_q != FILL_DONE) fill_q <= fill_q + 1'b1;
        end
    end

    assign s_prev_o = prev_q;
    assign valid_o  = (fill_q == FILL_DONE);

endmodule
`default_nettype wire

// File: rtl/ppu_fetch_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_fetch_tracker
//  Purpose  : PPU-bus observer for latch-style CHR mappers. Synchronizes the
//             PPU strobes/address, emits one registered event per access
//             (NT/AT/PT read or write) and tracks rendering state (in-frame
//             flag, scanline counter from the triple dummy NT fetch).
//  Ports    : clk, rst_n            - mapper clock, async active-low reset
//             ppu_addr_i[13:0]      - raw PPU address
//             ppu_oe_i, ppu_we_i    - raw /RD, /WR (active low)
//             fetch_stb_o           - one-clock pulse per access
//             fetch_kind_o[2:0]     - PpuFetchKind, held until next strobe
//             fetch_addr_o[13:0]    - access address, held until next strobe
//             line_stb_o            - one-clock pulse at scanline end
//             line_cnt_o[7:0]       - scanlines since frame start
//             in_frame_o            - rendering reads observed
//  Revision : 1.0 - initial release
// ============================================================================
module ppu_fetch_tracker
    import ppu_fetch_tracker_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDLE_CYC    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] ppu_addr_i,
    input  logic        ppu_oe_i,
    input  logic        ppu_we_i,
    output logic        fetch_stb_o,
    output logic [2:0]  fetch_kind_o,
    output logic [13:0] fetch_addr_o,
    output logic        line_stb_o,
    output logic [7:0]  line_cnt_o,
    output logic        in_frame_o
);

    localparam logic [7:0] IDLE_LIM = 8'(IDLE_CYC);

    logic [BUS_W-1:0]  w_cur;
    logic [1:0]        w_prev;
    logic              w_sync_valid;
    logic [PPU_AW-1:0] w_cur_addr;
    logic              w_rd_edge;
    logic              w_wr_edge;
    logic              w_nt_evt;
    logic              w_same;
    logic              w_timeout;
    PpuFetchKind       w_rd_kind;

    logic              fetch_stb_q, fetch_stb_d;
    PpuFetchKind       kind_q, kind_d;
    logic [PPU_AW-1:0] addr_q, addr_d;
    logic [7:0]        idle_cnt_q, idle_cnt_d;
    ScanState          state_q, state_d;
    logic [PPU_AW-1:0] last_nt_q, last_nt_d;
    logic              line_stb_q, line_stb_d;
    logic [7:0]        line_cnt_q, line_cnt_d;
    logic              in_frame_q, in_frame_d;

    ppu_edge_sync #(
        .WIDTH   (BUS_W),
        .STAGES  (SYNC_STAGES),
        .PREV_W  (2),
        .RST_VAL (BUS_IDLE)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_i      ({ppu_addr_i, ppu_oe_i, ppu_we_i}),
        .s_cur_o  (w_cur),
        .s_prev_o (w_prev),
        .valid_o  (w_sync_valid)
    );

    assign w_cur_addr = w_cur[BUS_W-1:2];
    assign w_rd_edge  = w_sync_valid & w_prev[1] & ~w_cur[1];
    // A write edge coinciding with a read edge is dropped: the read wins.
    assign w_wr_edge  = w_sync_valid & w_prev[0] & ~w_cur[0] & ~w_rd_edge;
    assign w_rd_kind  = classify_read(w_cur_addr);
    assign w_nt_evt   = w_rd_edge & (w_rd_kind == FK_NT);
    assign w_same     = (w_cur_addr == last_nt_q);
    assign w_timeout  = (idle_cnt_q >= IDLE_LIM);

    // Event register and idle counter
    always_comb begin
        fetch_stb_d = w_rd_edge | w_wr_edge;
        kind_d      = kind_q;
        addr_d      = addr_q;
        if (w_rd_edge) begin
            kind_d = w_rd_kind;
            addr_d = w_cur_addr;
        end else if (w_wr_edge) begin
            kind_d = FK_WR;
            addr_d = w_cur_addr;
        end

        if (w_rd_edge)                idle_cnt_d = '0;
        else if (idle_cnt_q != 8'hFF) idle_cnt_d = idle_cnt_q + 8'd1;
        else                          idle_cnt_d = idle_cnt_q;
    end

    // Scanline FSM: the PPU ends each line with three identical NT fetches.
    always_comb begin
        state_d    = state_q;
        last_nt_d  = last_nt_q;
        line_stb_d = 1'b0;
        line_cnt_d = line_cnt_q;
        in_frame_d = in_frame_q;
        if (w_nt_evt) begin
            last_nt_d = w_cur_addr;
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_RUN;
                    in_frame_d = 1'b1;
                    line_cnt_d = '0;
                end
                ST_RUN:  if (w_same) state_d = ST_DUP1;
                ST_DUP1: begin
                    if (w_same) begin
                        state_d    = ST_DUP2;
                        line_stb_d = 1'b1;
                        line_cnt_d = line_cnt_q + 8'd1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DUP2: state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end else if (w_timeout && !w_rd_edge) begin
            state_d    = ST_IDLE;
            in_frame_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_stb_q <= 1'b0;
            kind_q      <= FK_NT;
            addr_q      <= '0;
            idle_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            last_nt_q   <= '0;
            line_stb_q  <= 1'b0;
            line_cnt_q  <= '0;
            in_frame_q  <= 1'b0;
        end else begin
            fetch_stb_q <= fetch_stb_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            idle_cnt_q  <= idle_cnt_d;
            state_q     <= state_d;
            last_nt_q   <= last_nt_d;
            line_stb_q  <= line_stb_d;
            line_cnt_q  <= line_cnt_d;
            in_frame_q  <= in_frame_d;
        end
    end

    assign fetch_stb_o  = fetch_stb_q;
    assign fetch_kind_o = kind_q;
    assign fetch_addr_o = addr_q;
    assign line_stb_o   = line_stb_q;
    assign line_cnt_o   = line_cnt_q;
    assign in_frame_o   = in_frame_q;

endmodule
`default_nettype wire
